// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the control decoder.
// Holds the PC, issues in-order word requests to instruction memory over a
// valid/ready handshake, tracks them in a small circular queue, and presents
// one instruction per cycle in the IF/ID register. A decoder redirect
// (pc_sel with a live, unstalled ID instruction) reloads the PC and kills
// every in-flight or buffered wrong-path fetch.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hazard hold, IF/ID keeps its contents
//   pc_sel            redirect request for the instruction in ID
//   alu_target        redirect target (low two bits ignored)
//   imem_req_*        request channel (valid/ready, word address)
//   imem_rsp_*        in-order response channel, no backpressure
//   id_valid          IF/ID holds a live instruction
//   id_instruction    instruction word to the decoder
//   id_pc             PC of id_instruction
//   id_pc_plus4       id_pc + 4
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] alu_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);
    localparam int              PW       = $clog2(QDEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(QDEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    logic [31:0]       pc_r;
    logic [31:0]       addr_r [QDEPTH];
    logic [31:0]       data_r [QDEPTH];
    logic [QDEPTH-1:0] filled_r;
    logic [QDEPTH-1:0] kill_r;
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [PW-1:0]     fill_r;      // oldest entry still waiting for its response
    logic [CW-1:0]     count_r;     // allocated entries
    logic [CW-1:0]     pend_r;      // allocated entries not yet filled

    logic        id_valid_r;
    logic [31:0] id_instruction_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc_plus4_r;

    logic        full_s;
    logic        hs_s;
    logic        redirect_s;
    logic        rsp_ok_s;
    logic        head_ready_s;
    logic        pop_s;
    logic        load_s;
    logic [31:0] head_data_s;

    // Handshake, redirect and head-of-queue decisions.
    // A response is only accepted when some entry is waiting for one, which
    // silently drops stale responses that outlive a reset. When the head is
    // unfilled it is by construction the oldest unfilled entry, so an
    // accepted response this cycle belongs to it and can bypass into ID.
    assign full_s       = (count_r == FULL_CNT);
    assign hs_s         = imem_req_valid & imem_req_ready;
    assign redirect_s   = pc_sel & id_valid_r & ~stall;
    assign rsp_ok_s     = imem_rsp_valid & (pend_r != {CW{1'b0}});
    assign head_ready_s = (count_r != {CW{1'b0}}) & (filled_r[head_r] | rsp_ok_s);
    assign head_data_s  = filled_r[head_r] ? data_r[head_r] : imem_rsp_data;
    assign pop_s        = ~stall & ~redirect_s & head_ready_s;
    assign load_s       = pop_s & ~kill_r[head_r];

    // Request is held off during reset so nothing leaks out before the PC is valid.
    assign imem_req_valid = rst_n & ~full_s;
    assign imem_req_addr  = pc_r;

    assign id_valid       = id_valid_r;
    assign id_instruction = id_instruction_r;
    assign id_pc          = id_pc_r;
    assign id_pc_plus4    = id_pc_plus4_r;

    // Program counter: redirect wins over the sequential increment of a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_s) begin
            pc_r <= alu_target & 32'hFFFF_FFFC;
        end else if (hs_s) begin
            pc_r <= pc_r + 32'd4;
        end
    end

    // Tracking queue: fill on response, free at head, allocate at tail.
    // Fill is written before the head clear so a bypassed head ends up empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                addr_r[i] <= 32'h0000_0000;
                data_r[i] <= 32'h0000_0000;
            end
            filled_r <= {QDEPTH{1'b0}};
            kill_r   <= {QDEPTH{1'b0}};
            head_r   <= {PW{1'b0}};
            tail_r   <= {PW{1'b0}};
            fill_r   <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            pend_r   <= {CW{1'b0}};
        end else begin
            if (rsp_ok_s) begin
                filled_r[fill_r] <= 1'b1;
                data_r[fill_r]   <= imem_rsp_data;
                fill_r           <= fill_r + PTR_ONE;
            end
            if (pop_s) begin
                filled_r[head_r] <= 1'b0;
                head_r           <= head_r + PTR_ONE;
            end
            if (redirect_s) begin
                kill_r <= {QDEPTH{1'b1}};
            end
            // A request accepted in the redirect cycle is already wrong-path.
            if (hs_s) begin
                addr_r[tail_r]   <= pc_r;
                filled_r[tail_r] <= 1'b0;
                kill_r[tail_r]   <= redirect_s;
                tail_r           <= tail_r + PTR_ONE;
            end
            count_r <= count_r + CW'(hs_s) - CW'(pop_s);
            pend_r  <= pend_r + CW'(hs_s) - CW'(rsp_ok_s);
        end
    end

    // IF/ID register: load a live head, drop to bubble otherwise, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_r       <= 1'b0;
            id_instruction_r <= NOP;
            id_pc_r          <= 32'h0000_0000;
            id_pc_plus4_r    <= 32'h0000_0004;
        end else if (load_s) begin
            id_valid_r       <= 1'b1;
            id_instruction_r <= head_data_s;
            id_pc_r          <= addr_r[head_r];
            id_pc_plus4_r    <= addr_r[head_r] + 32'd4;
        end else if (!stall) begin
            id_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural model keeps the fetch
// queue as a list of {addr, data, filled, kill} records and the memory as a
// list of pending responses with random in-order latency; every cycle the
// DUT outputs are compared against the model on the falling edge.
module tb_fetch_unit;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] alu_target = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel),
        .alu_target(alu_target), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_instruction(id_instruction),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          filled;
        bit          kill;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    ent_t        m_q[$];
    pend_t       mem_q[$];
    logic [31:0] m_pc;
    bit          m_idv;
    logic [31:0] m_ins;
    logic [31:0] m_ipc;

    int cyc = 0;
    int last_due = 0;
    int n_checks = 0;
    int n_errors = 0;
    int k_ready = 100;
    int k_stall = 0;
    int k_sel = 0;
    int lat_lo = 1;
    int lat_hi = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        else if (a == 32'h4) return 32'h0010_0113;
        else return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_q.delete();
        m_idv = 1'b0;
        m_ins = 32'h0000_0013;
        m_ipc = 32'h0;
    endtask

    // One rising edge of the reference behaviour, using the inputs driven for it.
    task automatic model_step();
        bit hs;
        bit redir;
        int lat;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hs    = (m_q.size() < QDEPTH) && imem_req_ready;
        redir = pc_sel && m_idv && !stall;
        if (imem_rsp_valid) begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (!m_q[i].filled) begin
                    m_q[i].filled = 1'b1;
                    m_q[i].data   = imem_rsp_data;
                    break;
                end
            end
        end
        if (!stall) begin
            if (!redir && m_q.size() > 0 && m_q[0].filled) begin
                m_idv = !m_q[0].kill;
                if (!m_q[0].kill) begin
                    m_ins = m_q[0].data;
                    m_ipc = m_q[0].addr;
                end
                void'(m_q.pop_front());
            end else begin
                m_idv = 1'b0;
            end
        end
        if (redir) begin
            for (int i = 0; i < m_q.size(); i++) m_q[i].kill = 1'b1;
        end
        if (hs) begin
            m_q.push_back('{addr: m_pc, data: 32'h0, filled: 1'b0, kill: redir});
            lat = $urandom_range(lat_hi, lat_lo);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mem_q.push_back('{addr: m_pc, due: last_due});
        end
        if (redir) m_pc = alu_target & 32'hFFFF_FFFC;
        else if (hs) m_pc = m_pc + 32'd4;
    endtask

    task automatic compare();
        logic exp_valid;
        exp_valid = rst_n && (m_q.size() < QDEPTH);
        check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
        if (exp_valid) check_eq("req_addr", imem_req_addr, m_pc);
        check_eq("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
        if (m_idv || !rst_n) begin
            check_eq("id_instruction", id_instruction, m_ins);
            check_eq("id_pc", id_pc, m_ipc);
            check_eq("id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
        end
    endtask

    task automatic drive();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99, 0) < k_ready);
        stall          = ($urandom_range(99, 0) < k_stall);
        pc_sel         = ($urandom_range(99, 0) < k_sel);
        alu_target     = $urandom_range(255, 0);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic do_reset(input int ncyc, input bit drop_mem);
        rst_n = 1'b0;
        model_reset();
        if (drop_mem) begin
            mem_q.delete();
            last_due = 0;
        end
        for (int i = 0; i < ncyc; i++) step_cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_id(input logic [31:0] want, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step_cycle();
            if (id_valid && id_pc == want) found = 1'b1;
        end
        check_eq(tag, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_next_id(input logic [31:0] want, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step_cycle();
            if (id_valid) found = 1'b1;
        end
        check_eq({tag, "_seen"}, {31'b0, found}, 32'd1);
        if (found) check_eq(tag, id_pc, want);
    endtask

    initial begin
        model_reset();
        // Reset values and first fetches with single-cycle memory.
        k_ready = 100; k_stall = 0; k_sel = 0; lat_lo = 1; lat_hi = 1;
        do_reset(2, 1'b1);
        step_cycle();
        step_cycle();
        check_eq("first_id_valid", {31'b0, id_valid}, 32'd1);
        check_eq("first_id_pc", id_pc, RESET_PC);
        check_eq("first_id_pc_plus4", id_pc_plus4, RESET_PC + 32'd4);
        step_cycle();
        check_eq("second_id_pc", id_pc, RESET_PC + 32'd4);
        for (int i = 0; i < 6; i++) step_cycle();

        // Memory refuses requests for 5 cycles.
        k_ready = 0;
        do_reset(1, 1'b1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_cycle();
            check_eq("hold_addr", imem_req_addr, RESET_PC);
            check_eq("hold_id_valid", {31'b0, id_valid}, 32'd0);
        end

        // Stall fills the queue, then fetch stops until release.
        k_ready = 100;
        imem_req_ready = 1'b1;
        wait_id(32'h4, 20, "pre_stall");
        k_stall = 100;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step_cycle();
        check_eq("stall_full", {31'b0, imem_req_valid}, 32'd0);
        k_stall = 0;
        stall = 1'b0;
        wait_next_id(32'h8, 10, "after_stall");
        for (int i = 0; i < 6; i++) step_cycle();

        // Redirect from a JAL at 0x8, then an unaligned target.
        do_reset(1, 1'b1);
        wait_id(32'h8, 20, "reach_jal");
        pc_sel = 1'b1;
        alu_target = 32'h40;
        step_cycle();
        wait_next_id(32'h40, 20, "redirect_40");
        pc_sel = 1'b1;
        alu_target = 32'h43;
        step_cycle();
        wait_next_id(32'h40, 20, "redirect_43");

        // Redirect requested during stall waits for the first unstalled cycle.
        wait_id(32'h48, 20, "reach_48");
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            pc_sel = 1'b1;
            alu_target = 32'h80;
            step_cycle();
            check_eq("stall_hold_pc", id_pc, 32'h48);
        end
        stall = 1'b0;
        pc_sel = 1'b1;
        alu_target = 32'h80;
        step_cycle();
        check_eq("redirect_bubble", {31'b0, id_valid}, 32'd0);
        wait_next_id(32'h80, 20, "redirect_80");

        // Reset with two requests outstanding; their responses arrive after release.
        k_ready = 100; lat_lo = 6; lat_hi = 6;
        do_reset(1, 1'b1);
        for (int i = 0; i < 3; i++) step_cycle();
        k_ready = 0;
        do_reset(1, 1'b0);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && mem_q.size() > 0; i++) step_cycle();
        check_eq("stale_drained", mem_q.size(), 32'd0);
        k_ready = 100; lat_lo = 1; lat_hi = 1;
        imem_req_ready = 1'b1;
        wait_next_id(RESET_PC, 20, "restart_pc");

        // Random traffic with variable latency, stalls and redirects.
        k_ready = 70; k_stall = 20; k_sel = 10; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2, 1'b1);
            step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
